// File: rtl/affine_filter_pkg.sv
// Shared constants for the 6-tap affine horizontal interpolator: widths, rounding and the
// per-phase coefficient table used by the tap multipliers.
package affine_filter_pkg;

  localparam int unsigned SAMPLE_W_DEF = 8;
  localparam int unsigned ACC_W_DEF    = 16;
  localparam int unsigned NUM_TAPS     = 6;
  localparam int          ROUND_OFS    = 32;
  localparam int          NORM_SH      = 6;

  typedef enum logic {StFill, StRun} fill_st_e;

  // Stored as 8-bit signed so the +64 centre tap of phase 0 is representable.
  localparam logic signed [7:0] COEF [16][6] = '{
    '{ 8'sd0,  8'sd0,   8'sd64, 8'sd0,   8'sd0,   8'sd0},
    '{ 8'sd1, -8'sd3,   8'sd63, 8'sd4,  -8'sd2,   8'sd1},
    '{ 8'sd1, -8'sd5,   8'sd62, 8'sd8,  -8'sd3,   8'sd1},
    '{ 8'sd2, -8'sd8,   8'sd60, 8'sd13, -8'sd4,   8'sd1},
    '{ 8'sd3, -8'sd10,  8'sd58, 8'sd17, -8'sd5,   8'sd1},
    '{ 8'sd3, -8'sd11,  8'sd52, 8'sd26, -8'sd8,   8'sd2},
    '{ 8'sd2, -8'sd9,   8'sd47, 8'sd31, -8'sd10,  8'sd3},
    '{ 8'sd3, -8'sd11,  8'sd45, 8'sd34, -8'sd10,  8'sd3},
    '{ 8'sd3, -8'sd11,  8'sd40, 8'sd40, -8'sd11,  8'sd3},
    '{ 8'sd3, -8'sd10,  8'sd34, 8'sd45, -8'sd11,  8'sd3},
    '{ 8'sd3, -8'sd10,  8'sd31, 8'sd47, -8'sd9,   8'sd2},
    '{ 8'sd2, -8'sd8,   8'sd26, 8'sd52, -8'sd11,  8'sd3},
    '{ 8'sd1, -8'sd5,   8'sd17, 8'sd58, -8'sd10,  8'sd3},
    '{ 8'sd1, -8'sd4,   8'sd13, 8'sd60, -8'sd8,   8'sd2},
    '{ 8'sd1, -8'sd3,   8'sd8,  8'sd62, -8'sd5,   8'sd1},
    '{ 8'sd1, -8'sd2,   8'sd4,  8'sd63, -8'sd3,   8'sd1}
  };

endpackage

// File: rtl/affine_tap_mult.sv
// One filter tap: selects this tap's coefficient by phase and multiplies the sample by it
// with a shift-add network.
module affine_tap_mult
  import affine_filter_pkg::*;
#(
  parameter int unsigned TAP      = 0,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF
) (
  input  logic [SAMPLE_W-1:0]     sample,
  input  logic [3:0]              frac_q,
  output logic signed [ACC_W-1:0] prod
);

  logic signed [7:0] coef;
  logic [7:0]        mag;
  logic [ACC_W-1:0]  acc;

  always_comb begin
    coef = COEF[frac_q][TAP];
    mag  = coef[7] ? 8'(-coef) : 8'(coef);
    acc  = '0;
    for (int b = 0; b < 8; b++) begin
      if (mag[b]) acc = acc + (ACC_W'(sample) << b);
    end
    prod = coef[7] ? -$signed(acc) : $signed(acc);
  end

endmodule

// File: rtl/affine_hfilter_6tap.sv
// Streaming 6-tap 1/16-pel horizontal interpolator: sliding window, three-stage
// product / sum / round-clip pipeline, with full-pipeline freeze on output backpressure.
module affine_hfilter_6tap
  import affine_filter_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                in_last,
  input  logic [3:0]          frac,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic                out_last
);

  logic                    stall, accept, launch;
  logic [2:0]              cnt_q;
  logic [3:0]              frac_q;
  fill_st_e                fill_st;
  logic [SAMPLE_W-1:0]     win_q   [NUM_TAPS];
  logic [SAMPLE_W-1:0]     win_nxt [NUM_TAPS];
  logic signed [ACC_W-1:0] prod    [NUM_TAPS];
  logic signed [ACC_W-1:0] p1_q    [NUM_TAPS];
  logic                    v1_q, l1_q, v2_q, l2_q;
  logic signed [ACC_W-1:0] sum_d, sum2_q, rnd, y;
  logic [SAMPLE_W-1:0]     clip;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign fill_st  = (cnt_q == 3'd6) ? StRun : StFill;
  // The accept that fills the sixth slot already completes a window.
  assign launch   = accept && (fill_st == StRun || cnt_q == 3'd5);

  always_comb begin
    for (int k = 0; k < 5; k++) win_nxt[k] = win_q[k+1];
    win_nxt[5] = in_sample;
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    affine_tap_mult #(
      .TAP      (k),
      .SAMPLE_W (SAMPLE_W),
      .ACC_W    (ACC_W)
    ) u_tap (
      .sample (win_nxt[k]),
      .frac_q (frac_q),
      .prod   (prod[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      frac_q <= '0;
      for (int k = 0; k < NUM_TAPS; k++) win_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_TAPS; k++) win_q[k] <= win_nxt[k];
      if (cnt_q == 3'd0) frac_q <= frac;
      if (in_last) begin
        cnt_q <= '0;
      end else if (fill_st == StFill) begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NUM_TAPS; k++) sum_d = sum_d + p1_q[k];
  end

  always_comb begin
    rnd = sum2_q + ACC_W'(ROUND_OFS);
    y   = rnd >>> NORM_SH;
    if (y[ACC_W-1]) begin
      clip = '0;
    end else if (|y[ACC_W-2:SAMPLE_W]) begin
      clip = '1;
    end else begin
      clip = y[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      l1_q       <= 1'b0;
      v2_q       <= 1'b0;
      l2_q       <= 1'b0;
      sum2_q     <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_last   <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) p1_q[k] <= '0;
    end else if (!stall) begin
      v1_q <= launch;
      l1_q <= launch && in_last;
      if (launch) begin
        for (int k = 0; k < NUM_TAPS; k++) p1_q[k] <= prod[k];
      end
      v2_q      <= v1_q;
      l2_q      <= l1_q;
      sum2_q    <= sum_d;
      out_valid <= v2_q;
      out_last  <= l2_q;
      if (v2_q) out_sample <= clip;
    end
  end

endmodule

// File: tb/tb_affine_hfilter_6tap.sv
// Randomised and directed bench for affine_hfilter_6tap, checked against a window-sum
// reference model of the interpolation filter.
module tb_affine_hfilter_6tap;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_sample = 8'd0;
  logic [3:0] frac = 4'd0;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_sample;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int hold_lo = -1;
  int hold_hi = -1;
  logic mon_en = 1'b0;

  logic [8:0] exp_q [$];
  logic [7:0] row_q [$];
  int         acc_cyc_q [$];
  int         out_cnt = 0;
  int         stall_seen = 0;
  int         first_out_cyc = -1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_sample = 8'd0;
  logic       prev_last = 1'b0;

  // Phases 0..8; phases 9..15 are the mirror images of 7..1.
  int base_tab [9][6] = '{
    '{0,   0, 64,  0,   0, 0},
    '{1,  -3, 63,  4,  -2, 1},
    '{1,  -5, 62,  8,  -3, 1},
    '{2,  -8, 60, 13,  -4, 1},
    '{3, -10, 58, 17,  -5, 1},
    '{3, -11, 52, 26,  -8, 2},
    '{2,  -9, 47, 31, -10, 3},
    '{3, -11, 45, 34, -10, 3},
    '{3, -11, 40, 40, -11, 3}
  };

  affine_hfilter_6tap dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .in_last    (in_last),
    .frac       (frac),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 9) < 7);
      2:       out_ready = !(cyc >= hold_lo && cyc < hold_hi);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int coef(input int ph, input int k);
    if (ph <= 8) return base_tab[ph][k];
    return base_tab[16 - ph][5 - k];
  endfunction

  task automatic push_expected(input int f, input bit has_last);
    int n;
    int acc;
    int y;
    n = row_q.size();
    for (int i = 0; i + 6 <= n; i++) begin
      acc = 0;
      for (int k = 0; k < 6; k++) acc += coef(f, k) * int'(row_q[i+k]);
      y = (acc + 32) >>> 6;
      if (y < 0) y = 0;
      else if (y > 255) y = 255;
      exp_q.push_back({has_last && (i + 6 == n), 8'(y)});
    end
  endtask

  task automatic send(input logic [7:0] s, input logic last, input logic [3:0] f);
    int guard;
    logic took;
    guard = 0;
    took = 1'b0;
    in_valid = 1'b1;
    in_sample = s;
    in_last = last;
    frac = f;
    while (!took) begin
      @(negedge clk);
      took = in_ready;
      if (took) acc_cyc_q.push_back(cyc);
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL send_timeout got=%0d expected=accept", guard);
        $fatal(1, "input never accepted");
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_row(input int f, input bit has_last, input int gap_pct);
    int n;
    n = row_q.size();
    push_expected(f, has_last);
    acc_cyc_q.delete();
    for (int i = 0; i < n; i++) begin
      send(row_q[i], has_last && (i == n - 1), (i == 0) ? 4'(f) : 4'($urandom_range(0, 15)));
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain_left", exp_q.size(), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (mon_en) begin
      check_val("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_sample", out_sample, prev_sample);
        check_val("hold_last", out_last, prev_last);
      end
      if (out_valid && !out_ready) stall_seen++;
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check_val("output_expected", int'(exp_q.size() != 0), 1);
        end else begin
          e = exp_q.pop_front();
          check_val("sample", out_sample, e[7:0]);
          check_val("last", out_last, e[8]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sample = out_sample;
      prev_last = out_last;
    end
  end

  initial begin
    int n0;
    int w;
    int f;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_sample", out_sample, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Constant row: latency and last flag.
    row_q.delete();
    repeat (10) row_q.push_back(8'd100);
    first_out_cyc = -1;
    n0 = out_cnt;
    send_row(5, 1'b1, 0);
    drain();
    check_val("latency", first_out_cyc - acc_cyc_q[5], 3);
    check_val("const_count", out_cnt - n0, 5);

    // Phase 0 passes w[2] through.
    row_q.delete();
    for (int i = 1; i <= 8; i++) row_q.push_back(8'(10 * i));
    n0 = out_cnt;
    send_row(0, 1'b1, 0);
    drain();
    check_val("ident_count", out_cnt - n0, 3);

    // Half-pel clipping in both directions.
    row_q = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0};
    send_row(8, 1'b1, 0);
    row_q = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255};
    send_row(8, 1'b1, 0);
    drain();

    // Four-cycle output hold mid-row.
    row_q.delete();
    repeat (16) row_q.push_back(8'($urandom_range(0, 255)));
    rdy_mode = 2;
    hold_lo = cyc + 10;
    hold_hi = hold_lo + 4;
    stall_seen = 0;
    n0 = out_cnt;
    send_row(int'($urandom_range(0, 15)), 1'b1, 0);
    drain();
    check_val("stall_cycles", stall_seen, 4);
    check_val("bp_count", out_cnt - n0, 11);
    rdy_mode = 0;

    // Back-to-back rows, phase 0 then 8.
    row_q.delete();
    repeat (8) row_q.push_back(8'($urandom_range(0, 255)));
    send_row(0, 1'b1, 0);
    row_q.delete();
    repeat (9) row_q.push_back(8'($urandom_range(0, 255)));
    send_row(8, 1'b1, 0);
    drain();

    // Short row produces nothing and does not disturb the next row.
    row_q.delete();
    repeat (3) row_q.push_back(8'($urandom_range(0, 255)));
    n0 = out_cnt;
    send_row(4, 1'b1, 0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check_val("short_count", out_cnt - n0, 0);
    row_q.delete();
    repeat (7) row_q.push_back(8'($urandom_range(0, 255)));
    send_row(11, 1'b1, 0);
    drain();

    // Reset with windows in flight; the next row latches a new phase.
    row_q.delete();
    repeat (8) row_q.push_back(8'($urandom_range(0, 255)));
    send_row(3, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_mid_out_valid", out_valid, 0);
    check_val("rst_mid_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    row_q.delete();
    repeat (9) row_q.push_back(8'($urandom_range(0, 255)));
    n0 = out_cnt;
    send_row(12, 1'b1, 0);
    drain();
    check_val("post_rst_count", out_cnt - n0, 4);

    // Random rows, gaps and backpressure.
    rdy_mode = 1;
    for (int r = 0; r < 14; r++) begin
      w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 20));
      f = int'($urandom_range(0, 15));
      row_q.delete();
      repeat (w) row_q.push_back(8'($urandom_range(0, 255)));
      send_row(f, 1'b1, 30);
    end
    drain();
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
